prach_hb2_pack: RTL and testbench
=================================

// Module: prach_hb2_pack
// PURPOSE
// - Polyphase packer that drives the input side of the half-band decimator.
// - Takes a TDM stream of IQ samples, one sample per valid cycle, tagged with a channel number.
// - For each channel it pairs consecutive samples: the even sample goes out on dout_dp1, the odd sample on dout_dp2.
// - Emits one packed pair per channel per two input samples, with matching dv/chn/sync.
// PARAMETERS
// - NUM_CHN   8   number of TDM channels tracked, 1..256; din_chn >= NUM_CHN is invalid
// PORTS
// - clk        in   1      clock; the whole block runs in this single domain
// - rst_n      in   1      reset, synchronous, active-low
// - din_dq     in   16x2   input sample, [0]=I, [1]=Q, signed
// - din_dv     in   1      din_dq/din_chn valid this cycle
// - din_chn    in   8      channel of din_dq
// - sync_in    in   1      frame sync pulse; may coincide with din_dv or stand alone
// - dout_dp1   out  16x2   even-phase sample of the pair, [0]=I, [1]=Q
// - dout_dp2   out  16x2   odd-phase sample of the pair, [0]=I, [1]=Q
// - dout_dv    out  1      pair valid, single-cycle pulse
// - dout_chn   out  8      channel of the pair
// - sync_out   out  1      first pair after a sync; only ever high with dout_dv
// - err_chn    out  1      sticky: an invalid channel was seen; cleared only by reset
// BEHAVIOUR
// - Per-channel state: phase[c] (0 = expecting the even sample) and hold[c] (32b stored even sample).
// - Processing a valid sample, din_dv=1 and din_chn<NUM_CHN, channel c:
//   - phase[c]=0: hold[c]<=din_dq and phase[c]<=1. No output.
//   - phase[c]=1: registered next cycle: dout_dp1<=hold[c], dout_dp2<=din_dq,
//     dout_chn<=c, dout_dv<=1. phase[c]<=0.
// - Latency: one cycle from the odd-sample input cycle to dout_dv. There is no backpressure.
// - Back-to-back samples on the same channel in consecutive cycles must pair correctly.
//   hold/phase written in cycle N are visible in cycle N+1 (register array, no RAM read hazard).
// - Interleaving is arbitrary; channel pairing is independent per channel.
// - Invalid channel: din_dv=1 and din_chn>=NUM_CHN. The sample is dropped, no state changes,
//   and err_chn<=1.
// - sync_in=1, with or without din_dv:
//   - Clear all phase[] to 0 before that cycle's sample is processed.
//     Any pending even samples are discarded.
//   - A sample arriving with sync_in is therefore an even sample.
//   - Set sync_pend<=1.
// - sync_out: asserted together with the first dout_dv after sync_pend was set. sync_pend then clears.
//   A new sync_in while sync_pend=1 restarts the process; it does not stack.
// - When no pair is emitted, dout_dv=0 and sync_out=0. dout_dp1/dp2/chn keep their last values.
// - Reset (rst_n=0 on any clock edge, including mid-pair):
//   - All outputs go to 0, err_chn=0, sync_pend=0, all phase[]=0.
//   - hold[] contents are don't-care.
//   - The first sample after reset on every channel is even.
// - Arithmetic: none. Samples pass through bit-exact with no sign extension or rounding.
// TESTING
// - ch0 samples I=1,2,3,4 (Q=-I) in consecutive cycles -> two pairs, each one cycle after
//   samples 2 and 4: (dp1=1,dp2=2) then (3,4), Q negated, chn=0.
// - Interleaved chn 0,1,2,0,1,2 with I=10..15 -> pairs ch0(10,13), ch1(11,14), ch2(12,15) on
//   cycles 4,5,6 after the first input.
// - ch3 gets I=7 (pending), then sync_in without dv, then ch3 I=8,9 -> one pair (8,9)
//   with sync_out=1; 7 is never output.
// - din_chn=NUM_CHN with dv -> no dout_dv, err_chn=1 from the next cycle and held until reset.
//   Other channels are unaffected.
// - ch5 gets I=5, rst_n low for 1 cycle, then I=6,7 -> a single pair (6,7).
//   All outputs are 0 during reset.
// - Random TDM traffic over 8 channels with random sync/gaps, compared against a scoreboard model ->
//   all pairs bit-exact; the sync_out count equals the number of syncs followed by a pair.

Source files
------------

// File: rtl/prach_hb2_pack.sv
// prach_hb2_pack: pairs even/odd samples per TDM channel
// and feeds the half-band decimator input with packed pairs.
module prach_hb2_pack #(
   parameter int NUM_CHN = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0][15:0] din_dq,
   input  logic             din_dv,
   input  logic [7:0]       din_chn,
   input  logic             sync_in,
   output logic [1:0][15:0] dout_dp1,
   output logic [1:0][15:0] dout_dp2,
   output logic             dout_dv,
   output logic [7:0]       dout_chn,
   output logic             sync_out,
   output logic             err_chn
);

   localparam int CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
   localparam logic [8:0] NUM9 = 9'(NUM_CHN);

   logic [NUM_CHN-1:0] phase;
   logic [1:0][15:0]   hold [NUM_CHN];
   logic               sync_pend;

   logic          chn_ok;
   logic [CW-1:0] cidx;
   logic          cur_phase;
   logic          emit;

   // Decode the incoming sample; a sync forces it to the even phase
   always_comb begin
      chn_ok    = din_dv && ({1'b0, din_chn} < NUM9);
      cidx      = din_chn[CW-1:0];
      cur_phase = sync_in ? 1'b0 : phase[cidx];
      emit      = chn_ok && cur_phase;
   end

   // Even-sample storage; contents are meaningless until phase says so
   always_ff @(posedge clk) begin
      if (chn_ok && !cur_phase)
         hold[cidx] <= din_dq;
   end

   // Phase tracking, pair output, sync and error flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase     <= '0;
         sync_pend <= 1'b0;
         dout_dp1  <= '0;
         dout_dp2  <= '0;
         dout_dv   <= 1'b0;
         dout_chn  <= '0;
         sync_out  <= 1'b0;
         err_chn   <= 1'b0;
      end else begin
         dout_dv  <= 1'b0;
         sync_out <= 1'b0;
         if (sync_in)
            phase <= '0;
         if (din_dv && !chn_ok)
            err_chn <= 1'b1;
         if (chn_ok) begin
            if (!cur_phase) begin
               phase[cidx] <= 1'b1;
            end else begin
               phase[cidx] <= 1'b0;
               dout_dp1    <= hold[cidx];
               dout_dp2    <= din_dq;
               dout_chn    <= din_chn;
               dout_dv     <= 1'b1;
               sync_out    <= sync_pend;
            end
         end
         if (sync_in)
            sync_pend <= 1'b1;
         else if (emit)
            sync_pend <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prach_hb2_pack.sv
// tb_prach_hb2_pack: directed cases plus random TDM traffic
// checked every cycle against a per-channel pairing model.
module tb_prach_hb2_pack;

   localparam int N = 8;

   logic             clk;
   logic             rst_n;
   logic [1:0][15:0] din_dq;
   logic             din_dv;
   logic [7:0]       din_chn;
   logic             sync_in;
   logic [1:0][15:0] dout_dp1;
   logic [1:0][15:0] dout_dp2;
   logic             dout_dv;
   logic [7:0]       dout_chn;
   logic             sync_out;
   logic             err_chn;

   prach_hb2_pack #(.NUM_CHN(N)) dut (
      .clk(clk), .rst_n(rst_n), .din_dq(din_dq), .din_dv(din_dv),
      .din_chn(din_chn), .sync_in(sync_in), .dout_dp1(dout_dp1),
      .dout_dp2(dout_dp2), .dout_dv(dout_dv), .dout_chn(dout_chn),
      .sync_out(sync_out), .err_chn(err_chn)
   );

   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;

   // model state: a pending even sample per channel
   bit          m_has [N];
   logic [31:0] m_even [N];
   bit          m_pend;
   logic [31:0] e_dp1, e_dp2;
   logic [7:0]  e_chn;
   bit          e_dv, e_sync, e_err;
   int          m_sync_cnt = 0;
   int          d_sync_cnt = 0;
   int          m_pairs = 0;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(int i);
      logic [15:0] a, q;
      a = 16'(i);
      q = 16'(-i);
      return {q, a};
   endfunction

   // reference: a pair appears when a channel already holds an even sample
   always @(posedge clk) begin
      if (!rst_n) begin
         foreach (m_has[k]) m_has[k] = 0;
         m_pend = 0;
         e_dp1 = 0; e_dp2 = 0; e_chn = 0;
         e_dv = 0; e_sync = 0; e_err = 0;
      end else begin
         e_dv = 0;
         e_sync = 0;
         if (sync_in)
            foreach (m_has[k]) m_has[k] = 0;
         if (din_dv && int'(din_chn) >= N)
            e_err = 1;
         if (din_dv && int'(din_chn) < N) begin
            if (!m_has[din_chn]) begin
               m_has[din_chn] = 1;
               m_even[din_chn] = din_dq;
            end else begin
               m_has[din_chn] = 0;
               e_dp1 = m_even[din_chn];
               e_dp2 = din_dq;
               e_chn = din_chn;
               e_dv = 1;
               e_sync = m_pend;
               m_pend = 0;
               m_pairs++;
               if (e_sync) m_sync_cnt++;
            end
         end
         if (sync_in) m_pend = 1;
      end
   end

   // per-cycle comparison of the whole output bundle
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("bundle",
             {dout_dv, sync_out, err_chn, dout_chn, dout_dp1, dout_dp2},
             {e_dv, e_sync, e_err, e_chn, e_dp1, e_dp2});
         if (dout_dv && sync_out) d_sync_cnt++;
      end
   end

   task automatic step(bit r, bit dv, int chn, logic [31:0] d, bit s);
      rst_n = r;
      din_dv = dv;
      din_chn = 8'(chn);
      din_dq = d;
      sync_in = s;
      @(negedge clk);
   endtask

   initial begin
      step(0, 0, 0, 0, 0);
      cmp_en = 1;
      step(0, 0, 0, 0, 0);
      chk("rst_out", {dout_dv, sync_out, err_chn, dout_chn, dout_dp1, dout_dp2}, 0);

      // ch0 1,2,3,4
      step(1, 1, 0, mk(1), 0);
      chk("t1_nopair", dout_dv, 0);
      step(1, 1, 0, mk(2), 0);
      chk("t1_p1", {dout_dv, dout_chn, dout_dp1, dout_dp2}, {1'b1, 8'd0, mk(1), mk(2)});
      step(1, 1, 0, mk(3), 0);
      chk("t1_gap", dout_dv, 0);
      step(1, 1, 0, mk(4), 0);
      chk("t1_p2", {dout_dv, dout_chn, dout_dp1, dout_dp2}, {1'b1, 8'd0, mk(3), mk(4)});

      // interleaved 0,1,2,0,1,2
      for (int k = 0; k < 6; k++) begin
         step(1, 1, k % 3, mk(10 + k), 0);
         if (k >= 3)
            chk("t2_pair", {dout_dv, dout_chn, dout_dp1, dout_dp2},
                {1'b1, 8'(k - 3), mk(7 + k), mk(10 + k)});
         else
            chk("t2_none", dout_dv, 0);
      end

      // sync discards the pending even sample
      step(1, 1, 3, mk(7), 0);
      step(1, 0, 0, 0, 1);
      chk("t3_sync_alone", {dout_dv, sync_out}, 0);
      step(1, 1, 3, mk(8), 0);
      chk("t3_even", dout_dv, 0);
      step(1, 1, 3, mk(9), 0);
      chk("t3_pair", {dout_dv, sync_out, dout_chn, dout_dp1, dout_dp2},
          {2'b11, 8'd3, mk(8), mk(9)});

      // invalid channel
      step(1, 1, N, mk(99), 0);
      chk("t4_err", {dout_dv, err_chn}, 2'b01);
      step(1, 1, 0, mk(20), 0);
      step(1, 1, 0, mk(21), 0);
      chk("t4_other", {dout_dv, err_chn, dout_dp1, dout_dp2}, {2'b11, mk(20), mk(21)});

      // reset mid-pair
      step(1, 1, 5, mk(5), 0);
      step(0, 0, 0, 0, 0);
      chk("t5_rst", {dout_dv, sync_out, err_chn, dout_chn, dout_dp1, dout_dp2}, 0);
      step(1, 1, 5, mk(6), 0);
      chk("t5_even", dout_dv, 0);
      step(1, 1, 5, mk(7), 0);
      chk("t5_pair", {dout_dv, dout_chn, dout_dp1, dout_dp2}, {1'b1, 8'd5, mk(6), mk(7)});

      // random TDM traffic
      m_sync_cnt = 0;
      d_sync_cnt = 0;
      m_pairs = 0;
      for (int k = 0; k < 4000; k++) begin
         int c;
         c = ($urandom_range(0, 39) == 0) ? N : int'($urandom_range(0, N - 1));
         step(1, $urandom_range(0, 3) != 0, c, $urandom,
              $urandom_range(0, 29) == 0);
      end
      step(1, 0, 0, 0, 0);
      chk("sync_count", d_sync_cnt, m_sync_cnt);
      chk("pairs_seen", m_pairs > 500, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
